// File: rtl/tone_detect.sv
// -----------------------------------------------------------------------------
// tone_detect
//
// Measures the period of an asynchronous square-wave tone and declares a stable
// tone once enough consecutive periods agree.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   tone_in      in   asynchronous tone input
//   period       out  last accepted period, in clocks
//   period_vld   out  one-cycle pulse when period updates
//   tone_on      out  high while locked
//   tone_period  out  period captured at lock, held while locked
//   lost         out  one-cycle pulse on any exit from LOCK (not on reset)
//   state_dbg    out  current FSM state (0=IDLE, 1=ACQ, 2=LOCK)
//
// Handshake: there is no backpressure. period_vld qualifies period for exactly
// one cycle; a consumer that is not ready simply misses that measurement.
// -----------------------------------------------------------------------------
module tone_detect #(
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 2500000,
   parameter int MIN_PERIOD = 1000,
   parameter int TOL        = 64,
   parameter int STABLE_N   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tone_in,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             tone_on,
   output logic [CNT_W-1:0] tone_period,
   output logic             lost,
   output logic [1:0]       state_dbg
);

   localparam int MC_W = $clog2(STABLE_N + 1);

   localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] MINP_C  = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [MC_W-1:0]  STB_C   = MC_W'(STABLE_N);
   localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACQ  = 2'd1,
      S_LOCK = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync2_q, edge_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ref_q, ref_d;
   logic [MC_W-1:0]  mc_q, mc_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             vld_q, vld_d;
   logic             on_q, on_d;
   logic [CNT_W-1:0] tper_q, tper_d;
   logic             lost_q, lost_d;

   logic             rise;
   logic             accept;
   logic             timeout;
   logic [MC_W-1:0]  acq_mc;

   // Unsigned distance, larger minus smaller, so no wrap-around.
   function automatic logic within_tol(input logic [CNT_W-1:0] a,
                                       input logic [CNT_W-1:0] b);
      logic [CNT_W-1:0] diff;
      diff = (a > b) ? (a - b) : (b - a);
      return (diff <= TOL_C);
   endfunction

   assign rise    = sync2_q & ~edge_q;
   // IDLE has no reference edge, so the glitch filter only applies once armed.
   assign accept  = rise & ((state_q == S_IDLE) | (cnt_q >= MINP_C));
   // An accepted rise in the saturated cycle wins over the timeout.
   assign timeout = (cnt_q == TMO_C) & ~accept;
   // A streak restarts whenever there is no previous measurement or it differs.
   assign acq_mc  = ((mc_q == '0) || !within_tol(cnt_q, ref_q)) ? MC_ONE : (mc_q + MC_ONE);

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      mc_d     = mc_q;
      period_d = period_q;
      vld_d    = 1'b0;
      on_d     = on_q;
      tper_d   = tper_q;
      lost_d   = 1'b0;

      if (accept) begin
         cnt_d = ONE_C;
      end else if (cnt_q >= TMO_C) begin
         cnt_d = TMO_C;
      end else begin
         cnt_d = cnt_q + ONE_C;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ACQ;
            end
         end
         S_ACQ: begin
            if (accept) begin
               period_d = cnt_q;
               vld_d    = 1'b1;
               ref_d    = cnt_q;
               mc_d     = acq_mc;
               if (acq_mc == STB_C) begin
                  state_d = S_LOCK;
                  on_d    = 1'b1;
                  tper_d  = cnt_q;
               end
            end else if (timeout) begin
               state_d = S_IDLE;
               mc_d    = '0;
               on_d    = 1'b0;
            end
         end
         S_LOCK: begin
            if (accept) begin
               period_d = cnt_q;
               vld_d    = 1'b1;
               // While locked the drift is judged against the lock value.
               if (!within_tol(cnt_q, tper_q)) begin
                  state_d = S_ACQ;
                  on_d    = 1'b0;
                  lost_d  = 1'b1;
                  ref_d   = cnt_q;
                  mc_d    = MC_ONE;
               end
            end else if (timeout) begin
               state_d = S_IDLE;
               mc_d    = '0;
               on_d    = 1'b0;
               lost_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         edge_q   <= 1'b0;
         cnt_q    <= '0;
         ref_q    <= '0;
         mc_q     <= '0;
         period_q <= '0;
         vld_q    <= 1'b0;
         on_q     <= 1'b0;
         tper_q   <= '0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= tone_in;
         sync2_q  <= sync1_q;
         edge_q   <= sync2_q;
         cnt_q    <= cnt_d;
         ref_q    <= ref_d;
         mc_q     <= mc_d;
         period_q <= period_d;
         vld_q    <= vld_d;
         on_q     <= on_d;
         tper_q   <= tper_d;
         lost_q   <= lost_d;
      end
   end

   assign period      = period_q;
   assign period_vld  = vld_q;
   assign tone_on     = on_q;
   assign tone_period = tper_q;
   assign lost        = lost_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_tone_detect.sv
module tb_tone_detect;

   localparam int CNT_W   = 32;
   localparam int TIMEOUT = 1000;

   logic             clk;
   logic             rst;
   logic             tone_in;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             tone_on;
   logic [CNT_W-1:0] tone_period;
   logic             lost;
   logic [1:0]       state_dbg;

   tone_detect #(
      .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_PERIOD(10), .TOL(4), .STABLE_N(4)
   ) dut (
      .clk(clk), .rst(rst), .tone_in(tone_in),
      .period(period), .period_vld(period_vld), .tone_on(tone_on),
      .tone_period(tone_period), .lost(lost), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [CNT_W+1:0] exp_q[$];   // {tone_on, lost, period}
   int               t_q[$];     // cycle stamp of the driven rise
   int lost_cnt     = 0;
   int lost_cyc     = 0;
   int last_vld_cyc = 0;
   int last_len     = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (period_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_vld", 64'(1), 64'(0));
         end else begin
            logic [CNT_W+1:0] e;
            int               s;
            e = exp_q.pop_front();
            s = t_q.pop_front();
            chk("period", 64'(period), 64'(e[CNT_W-1:0]));
            chk("tone_on_at_vld", 64'(tone_on), 64'(e[CNT_W+1]));
            chk("lost_at_vld", 64'(lost), 64'(e[CNT_W]));
            chk("latency", 64'(cyc - s), 64'(3));
         end
         last_vld_cyc = cyc;
      end
      if (lost === 1'b1) begin
         lost_cnt = lost_cnt + 1;
         lost_cyc = cyc;
      end
   end

   // ---------------- driver ----------------
   // One full tone period starting with a rising edge; the measurement it
   // reports is the length of the previous period.
   task automatic pulse(input int hi, input int lo, input bit chk_en,
                        input logic on, input logic ls);
      @(negedge clk);
      tone_in = 1'b1;
      if (chk_en) begin
         exp_q.push_back({on, ls, CNT_W'(last_len)});
         t_q.push_back(cyc);
      end
      last_len = hi + lo;
      repeat (hi) @(negedge clk);
      tone_in = 1'b0;
      repeat (lo - 1) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {period, tone_period}, 64'(0));
      chk(tag, 64'({period_vld, tone_on, lost, state_dbg}), 64'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      rst     = 1'b1;
      tone_in = 1'b0;

      // 1: reset held while the pin toggles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_zero("reset_hold");
         tone_in = (i < 2) ? ~tone_in : 1'b0;
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk_zero("after_release");

      // 2: clean 50-clock tone, lock on rise 5
      pulse(25, 25, 1'b0, 1'b0, 1'b0);
      pulse(25, 25, 1'b1, 1'b0, 1'b0);
      pulse(25, 25, 1'b1, 1'b0, 1'b0);
      pulse(25, 25, 1'b1, 1'b0, 1'b0);
      pulse(26, 26, 1'b1, 1'b1, 1'b0);   // rise 5 locks at 50; next period 52
      chk("tone_period_lock", 64'(tone_period), 64'(50));
      chk("state_lock", 64'(state_dbg), 64'(2));

      // 3: drift within tolerance, then a jump, then re-lock
      pulse(24, 23, 1'b1, 1'b1, 1'b0);   // reports 52
      pulse(27, 27, 1'b1, 1'b1, 1'b0);   // reports 47
      pulse(35, 35, 1'b1, 1'b1, 1'b0);   // reports 54 (edge of tolerance)
      chk("tone_period_held", 64'(tone_period), 64'(50));
      base = lost_cnt;
      pulse(25, 25, 1'b1, 1'b0, 1'b1);   // reports 70 -> lost
      chk("lost_on_jump", 64'(lost_cnt - base), 64'(1));
      pulse(25, 25, 1'b1, 1'b0, 1'b0);   // 50 vs 70: restart streak
      pulse(25, 25, 1'b1, 1'b0, 1'b0);
      pulse(25, 25, 1'b1, 1'b0, 1'b0);
      pulse(25, 25, 1'b1, 1'b1, 1'b0);   // fourth matching 50 re-locks
      chk("tone_period_relock", 64'(tone_period), 64'(50));

      // 4: short glitch after a rise is ignored
      base = lost_cnt;
      @(negedge clk);
      tone_in = 1'b1;
      exp_q.push_back({1'b1, 1'b0, CNT_W'(last_len)});
      t_q.push_back(cyc);
      last_len = 50;
      repeat (3) @(negedge clk);
      tone_in = 1'b0;
      repeat (2) @(negedge clk);
      tone_in = 1'b1;
      repeat (2) @(negedge clk);
      tone_in = 1'b0;
      repeat (42) @(negedge clk);
      pulse(25, 25, 1'b1, 1'b1, 1'b0);   // true rise reports 50
      chk("no_lost_glitch", 64'(lost_cnt - base), 64'(0));

      // 5: silence -> timeout exactly TIMEOUT clocks after last measurement
      base = lost_cnt;
      for (int i = 0; i < TIMEOUT + 200 && lost_cnt == base; i++) @(negedge clk);
      chk("timeout_lost", 64'(lost_cnt - base), 64'(1));
      chk("timeout_delay", 64'(lost_cyc - last_vld_cyc), 64'(TIMEOUT));
      chk("timeout_tone_on", 64'(tone_on), 64'(0));
      chk("timeout_period_hold", 64'(period), 64'(50));
      chk("timeout_state", 64'(state_dbg), 64'(0));
      repeat (20) @(negedge clk);
      chk("timeout_lost_once", 64'(lost_cnt - base), 64'(1));
      pulse(25, 25, 1'b0, 1'b0, 1'b0);   // first edge again: no report

      // 6: alternating 50/60 never locks, then reset mid-run
      pulse(30, 30, 1'b1, 1'b0, 1'b0);   // 50
      pulse(25, 25, 1'b1, 1'b0, 1'b0);   // 60
      pulse(30, 30, 1'b1, 1'b0, 1'b0);   // 50
      pulse(25, 25, 1'b1, 1'b0, 1'b0);   // 60
      pulse(30, 30, 1'b1, 1'b0, 1'b0);   // 50
      chk("alt_state_acq", 64'(state_dbg), 64'(1));
      base = lost_cnt;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("mid_reset");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("mid_reset_release");
      chk("mid_reset_no_lost", 64'(lost_cnt - base), 64'(0));
      pulse(25, 25, 1'b0, 1'b0, 1'b0);   // treated as first edge
      pulse(25, 25, 1'b1, 1'b0, 1'b0);   // 50, streak of one
      repeat (5) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
